// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, TX FSM state type and hex-to-ASCII conversion.
package uart_pkg;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned FRAME_BITS = 10;
    localparam logic [7:0]  ASCII_CR   = 8'h0D;
    localparam logic [7:0]  ASCII_LF   = 8'h0A;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } tx_state_e;

    // Uppercase only: 10..15 map to 'A'..'F'.
    function automatic logic [7:0] hex_to_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 byte serialiser. A byte offered on valid_i while ready_o is high is latched and sent;
// ready_o also rises in the last stop-bit cycle so characters can be chained without a gap.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned BitCycles = 10
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       tx_o
);

    localparam int unsigned CntW = (BitCycles > 1) ? $clog2(BitCycles) : 1;

    tx_state_e       state_q, state_d;
    logic [CntW-1:0] baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      data_q, data_d;
    logic            baud_last;

    assign baud_last = (baud_q == CntW'(BitCycles - 1));

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        data_d  = data_q;
        baud_d  = baud_last ? '0 : baud_q + CntW'(1);
        ready_o = 1'b0;
        tx_o    = 1'b1;
        unique case (state_q)
            StIdle: begin
                ready_o = 1'b1;
                baud_d  = '0;
                if (valid_i) begin
                    data_d  = data_i;
                    state_d = StStart;
                end
            end
            StStart: begin
                tx_o = 1'b0;
                if (baud_last) begin
                    bit_d   = '0;
                    state_d = StData;
                end
            end
            StData: begin
                tx_o = data_q[bit_q];
                if (baud_last) begin
                    if (bit_q == 3'(DATA_BITS - 1)) begin
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            StStop: begin
                if (baud_last) begin
                    ready_o = 1'b1;
                    if (valid_i) begin
                        data_d  = data_i;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/uart_output_manager.sv
// Sends a DIGIT_COUNT-nibble word as uppercase ASCII hex over 8N1, nibble 0 first.
// Define UART_OUT_CRLF_EN to append CR and LF frames after the last digit.
module uart_output_manager
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_RATE  = 100_000_000,
    parameter int unsigned BAUD_RATE   = 9600,
    parameter int unsigned DIGIT_COUNT = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DIGIT_COUNT*4-1:0] in,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     RsTx
);

    localparam int unsigned BitCycles = CLOCK_RATE / BAUD_RATE;
`ifdef UART_OUT_CRLF_EN
    localparam int unsigned NumChars = DIGIT_COUNT + 2;
`else
    localparam int unsigned NumChars = DIGIT_COUNT;
`endif
    localparam int unsigned IdxW = $clog2(NumChars + 1);
    // One spare zero nibble so the look-ahead slice [7:4] exists even for a single digit.
    localparam int unsigned ShW  = (DIGIT_COUNT + 1) * 4;

    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [ShW-1:0]  sh_q, sh_d;
    logic            tx_ready, tx_valid;
    logic [7:0]      tx_data, next_char;
    logic            last_char;

    assign last_char = (idx_q == IdxW'(NumChars - 1));

    // Character following the one currently on the line.
    always_comb begin
        next_char = hex_to_ascii(sh_q[7:4]);
`ifdef UART_OUT_CRLF_EN
        if (32'(idx_q) + 32'd1 == DIGIT_COUNT) begin
            next_char = ASCII_CR;
        end else if (32'(idx_q) + 32'd1 == DIGIT_COUNT + 1) begin
            next_char = ASCII_LF;
        end
`endif
    end

    always_comb begin
        busy_d   = busy_q;
        done_d   = 1'b0;
        idx_d    = idx_q;
        sh_d     = sh_q;
        tx_valid = 1'b0;
        tx_data  = next_char;
        if (!busy_q) begin
            if (start) begin
                tx_valid = 1'b1;
                tx_data  = hex_to_ascii(in[3:0]);
                busy_d   = 1'b1;
                idx_d    = '0;
                sh_d     = {4'h0, in};
            end
        end else if (tx_ready) begin
            if (last_char) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                tx_valid = 1'b1;
                idx_d    = idx_q + IdxW'(1);
                sh_d     = sh_q >> 4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            idx_q  <= '0;
            sh_q   <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            idx_q  <= idx_d;
            sh_q   <= sh_d;
        end
    end

    uart_tx #(
        .BitCycles(BitCycles)
    ) u_tx (
        .clk_i  (clk),
        .reset_i(reset),
        .data_i (tx_data),
        .valid_i(tx_valid),
        .ready_o(tx_ready),
        .tx_o   (RsTx)
    );

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_uart_output_manager.sv
// Directed bench for uart_output_manager (BIT_CYCLES=10, 4 digits); honours UART_OUT_CRLF_EN.
module tb_uart_output_manager;

    localparam int Bc       = 10;
    localparam int FrameCyc = 10 * Bc;
`ifdef UART_OUT_CRLF_EN
    localparam int NChars = 6;
`else
    localparam int NChars = 4;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in;
    logic        start;
    logic        busy;
    logic        done;
    logic        RsTx;

    int errors = 0;
    int checks = 0;

    uart_output_manager #(
        .CLOCK_RATE (100),
        .BAUD_RATE  (10),
        .DIGIT_COUNT(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .in   (in),
        .start(start),
        .busy (busy),
        .done (done),
        .RsTx (RsTx)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input logic obs, input logic exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk(RsTx, 1'b1, {tag, " rstx"});
        chk(busy, 1'b0, {tag, " busy"});
        chk(done, 1'b0, {tag, " done"});
    endtask

    // Entered at the negedge of the first cycle of a word; leaves at the negedge of the done cycle.
    // exp holds the four digit characters, first-sent in the low byte.
    task automatic check_word(input logic [31:0] exp, input string tag);
        logic [7:0] ch;
        logic       bit_e;
        int         c;
        int         pos;
        for (int k = 0; k < NChars * FrameCyc; k++) begin
            c   = k / FrameCyc;
            pos = (k % FrameCyc) / Bc;
            if (c < 4)       ch = exp[c*8 +: 8];
            else if (c == 4) ch = 8'h0D;
            else             ch = 8'h0A;
            if (pos == 0)      bit_e = 1'b0;
            else if (pos == 9) bit_e = 1'b1;
            else               bit_e = ch[pos-1];
            chk(RsTx, bit_e, $sformatf("%s k=%0d rstx", tag, k));
            chk(busy, 1'b1, $sformatf("%s k=%0d busy", tag, k));
            chk(done, 1'b0, $sformatf("%s k=%0d done", tag, k));
            @(negedge clk);
        end
        chk(done, 1'b1, {tag, " done pulse"});
        chk(busy, 1'b0, {tag, " busy at done"});
        chk(RsTx, 1'b1, {tag, " rstx at done"});
    endtask

    task automatic send_and_check(input logic [15:0] word, input logic [31:0] exp,
                                  input string tag);
        @(negedge clk);
        in    = word;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_word(exp, tag);
        @(negedge clk);
        chk_idle({tag, " after"});
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        in    = 16'h0000;
        repeat (3) @(negedge clk);
        chk_idle("reset");
        reset = 1'b0;
        @(negedge clk);
        chk_idle("post-reset");

        send_and_check(16'h3A5F, 32'h33413546, "w3A5F");
        send_and_check(16'h0000, 32'h30303030, "w0000");
        send_and_check(16'hFFFF, 32'h46464646, "wFFFF");

        // start held high: changes to in mid-word are ignored; next word starts after done.
        @(negedge clk);
        in    = 16'h1234;
        start = 1'b1;
        fork
            begin
                repeat (150) @(negedge clk);
                in = 16'hABCD;
            end
        join_none
        @(negedge clk);
        check_word(32'h31323334, "held1");
        @(negedge clk);
        start = 1'b0;
        check_word(32'h41424344, "held2");
        @(negedge clk);
        chk_idle("held after");

        // Reset during DATA of digit 2 ('A' = 0x41, bit 2 on the line at k=230 is 0).
        @(negedge clk);
        in    = 16'h3A5F;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (230) @(negedge clk);
        chk(RsTx, 1'b0, "midreset data bit");
        chk(busy, 1'b1, "midreset busy before");
        reset = 1'b1;
        @(negedge clk);
        chk_idle("midreset next");
        reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk_idle($sformatf("midreset quiet %0d", i));
        end
        send_and_check(16'hC0DE, 32'h43304445, "wC0DE");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
